// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its loader.
// Holds the loader state encoding, text base address and memory depth.
package imem_pkg;

    localparam logic [31:0] TEXT_BASE  = 32'h0040_0000;
    localparam int          IMEM_DEPTH = 64;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_LEN0 = 3'd1,
        LD_LEN1 = 3'd2,
        LD_DATA = 3'd3,
        LD_CHK  = 3'd4,
        LD_DONE = 3'd5
    } loader_state_t;

    // Byte address of a word index, computed at full 32-bit width.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
        return base + {14'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word is registered on the 4th byte (1 cycle).
// No backpressure of its own: every asserted i_byte_vld is taken.
module byte_word_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_byte_vld,
    input  logic [7:0]  i_byte,
    output logic        o_last_byte,
    output logic        o_word_vld,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;
    logic [31:0] r_word;
    logic        r_word_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= 2'd0;
            r_shift    <= 24'd0;
            r_word     <= 32'd0;
            r_word_vld <= 1'b0;
        end else begin
            r_word_vld <= 1'b0;
            if (i_clr) begin
                r_cnt   <= 2'd0;
                r_shift <= 24'd0;
            end else if (i_byte_vld) begin
                r_cnt <= r_cnt + 2'd1;
                case (r_cnt)
                    2'd0: r_shift[7:0]   <= i_byte;
                    2'd1: r_shift[15:8]  <= i_byte;
                    2'd2: r_shift[23:16] <= i_byte;
                    default: begin
                        r_word     <= {i_byte, r_shift};
                        r_word_vld <= 1'b1;
                        r_shift    <= 24'd0;
                    end
                endcase
            end
        end
    end

    assign o_last_byte = (r_cnt == 2'd3);
    assign o_word_vld  = r_word_vld;
    assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (length, LE words, XOR checksum) into imem via its write port; write 1 cycle after 4th byte.
// in_ready is high in every busy state, so the host alone paces the stream; core held in reset while busy.
module imem_loader
    import imem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TEXT_BASE,
    parameter int          DEPTH     = IMEM_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        busy,
    output logic        hold_cpu,
    output logic        done,
    output logic        err
);

    localparam logic [31:0] L_DEPTH = DEPTH[31:0];

    loader_state_t r_state;
    loader_state_t w_next;

    logic [15:0] r_len;
    logic [15:0] r_idx;
    logic [7:0]  r_csum;
    logic        r_err;
    logic [31:0] r_wa;

    logic        w_hs;
    logic        w_start_ok;
    logic [15:0] w_len_full;
    logic        w_oversize;
    logic        w_last_word;
    logic        w_pk_last;
    logic        w_pk_vld;
    logic [31:0] w_pk_word;

    assign w_hs        = in_valid && in_ready;
    assign w_start_ok  = start && ((r_state == LD_IDLE) || (r_state == LD_DONE));
    assign w_len_full  = {in_data, r_len[7:0]};
    assign w_oversize  = {16'd0, w_len_full} > L_DEPTH;
    assign w_last_word = (r_idx == (r_len - 16'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            LD_IDLE, LD_DONE: begin
                if (start) w_next = LD_LEN0;
            end
            LD_LEN0: begin
                if (w_hs) w_next = LD_LEN1;
            end
            LD_LEN1: begin
                if (w_hs) begin
                    if (w_oversize)              w_next = LD_DONE;
                    else if (w_len_full == 16'd0) w_next = LD_CHK;
                    else                          w_next = LD_DATA;
                end
            end
            LD_DATA: begin
                if (w_hs && w_pk_last && w_last_word) w_next = LD_CHK;
            end
            LD_CHK: begin
                if (w_hs) w_next = LD_DONE;
            end
            default: w_next = LD_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        case (r_state)
            LD_LEN0, LD_LEN1, LD_DATA, LD_CHK: busy = 1'b1;
            LD_DONE:                           done = 1'b1;
            default: ;
        endcase
        in_ready = busy;
        hold_cpu = busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len  <= 16'd0;
            r_idx  <= 16'd0;
            r_csum <= 8'd0;
            r_err  <= 1'b0;
            r_wa   <= BASE_ADDR;
        end else if (w_start_ok) begin
            r_idx  <= 16'd0;
            r_csum <= 8'd0;
            r_err  <= 1'b0;
        end else if (w_hs) begin
            case (r_state)
                LD_LEN0: begin
                    r_len[7:0] <= in_data;
                    r_csum     <= r_csum ^ in_data;
                end
                LD_LEN1: begin
                    r_len[15:8] <= in_data;
                    r_csum      <= r_csum ^ in_data;
                    if (w_oversize) r_err <= 1'b1;
                end
                LD_DATA: begin
                    r_csum <= r_csum ^ in_data;
                    // Address is registered with the word so wa/wd line up with the we pulse.
                    if (w_pk_last) begin
                        r_wa  <= word_addr(BASE_ADDR, r_idx);
                        r_idx <= r_idx + 16'd1;
                    end
                end
                LD_CHK: begin
                    r_err <= (in_data != r_csum);
                end
                default: ;
            endcase
        end
    end

    byte_word_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (w_start_ok),
        .i_byte_vld  (w_hs && (r_state == LD_DATA)),
        .i_byte      (in_data),
        .o_last_byte (w_pk_last),
        .o_word_vld  (w_pk_vld),
        .o_word      (w_pk_word)
    );

    assign we  = w_pk_vld;
    assign wd  = w_pk_word;
    assign wa  = r_wa;
    assign err = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames plus hand sequences; writes checked against a scoreboard queue.
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        busy;
    logic        hold_cpu;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int we_count = 0;

    logic [63:0] sb_q[$];
    logic [31:0] mem [0:63];

    typedef struct {
        int              n;
        logic [2:0][31:0] w;
        bit              bad_csum;
        int              gap_max;
        bit              exp_err;
    } frame_vec_t;

    frame_vec_t tbl [5];

    imem_loader #(.BASE_ADDR(BASE), .DEPTH(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .busy     (busy),
        .hold_cpu (hold_cpu),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Write monitor: every we pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            logic [63:0] e;
            int idx;
            we_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write wa=%h wd=%h", wa, wd);
            end else begin
                e = sb_q.pop_front();
                if (wa !== e[63:32] || wd !== e[31:0]) begin
                    errors++;
                    $display("FAIL write actual wa=%h wd=%h expected wa=%h wd=%h", wa, wd, e[63:32], e[31:0]);
                end
            end
            idx = int'((wa - BASE) >> 2);
            if (idx >= 0 && idx < 64) mem[idx] = wd;
        end
    end

    // Called at a negedge; returns at the negedge after the byte was consumed.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=%b expected=1", in_ready);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
        chk("start_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send_frame(input frame_vec_t f, input string tag);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] n16;
        cs  = 8'h00;
        n16 = f.n[15:0];
        do_start();
        send_byte(n16[7:0], 0);  cs ^= n16[7:0];
        send_byte(n16[15:8], $urandom_range(0, f.gap_max)); cs ^= n16[15:8];
        for (int i = 0; i < f.n; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = f.w[i][8*k +: 8];
                if (k == 3) sb_q.push_back({BASE + 32'(4 * i), f.w[i]});
                send_byte(b, $urandom_range(0, f.gap_max));
                cs ^= b;
                if (k == 3) chk({tag, "_we_latency"}, {31'd0, we}, 32'd1);
            end
        end
        send_byte(f.bad_csum ? 8'h00 : cs, $urandom_range(0, f.gap_max));
        in_valid = 1'b0;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_err"}, {31'd0, err}, {31'd0, f.exp_err});
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_hold"}, {31'd0, hold_cpu}, 32'd0);
        chk({tag, "_sb_empty"}, sb_q.size(), 32'd0);
    endtask

    initial begin
        int wc;
        // Hard stop in case something wedges.
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wc;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;

        tbl[0].n = 1; tbl[0].w[0] = 32'h3E802403; tbl[0].w[1] = 0; tbl[0].w[2] = 0;
        tbl[0].bad_csum = 0; tbl[0].gap_max = 0; tbl[0].exp_err = 0;
        tbl[1].n = 3; tbl[1].w[0] = 32'h3E802403; tbl[1].w[1] = 32'h3EC02483; tbl[1].w[2] = 32'h00940533;
        tbl[1].bad_csum = 0; tbl[1].gap_max = 3; tbl[1].exp_err = 0;
        tbl[2].n = 1; tbl[2].w[0] = 32'h3E802403; tbl[2].w[1] = 0; tbl[2].w[2] = 0;
        tbl[2].bad_csum = 1; tbl[2].gap_max = 0; tbl[2].exp_err = 1;
        tbl[3].n = 0; tbl[3].w = '0;
        tbl[3].bad_csum = 1; tbl[3].gap_max = 0; tbl[3].exp_err = 0;
        tbl[4].n = 2; tbl[4].w[0] = 32'hDEADBEEF; tbl[4].w[1] = 32'h01234567; tbl[4].w[2] = 0;
        tbl[4].bad_csum = 0; tbl[4].gap_max = 1; tbl[4].exp_err = 0;

        // Reset with start and in_valid asserted.
        rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_wa", wa, BASE);
        chk("rst_wd", wd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold", {31'd0, hold_cpu}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            send_frame(tbl[i], $sformatf("frame%0d", i));
            if (i == 0) chk("imem_read_0", mem[0], 32'h3E802403);
            repeat (2) @(negedge clk);
        end
        chk("imem_read_2", mem[2], 32'h00940533);

        // Oversize length: done/err one cycle after second header byte, no writes, no more bytes taken.
        wc = we_count;
        do_start();
        send_byte(8'h41, 0);
        send_byte(8'h00, 0);
        chk("over_done", {31'd0, done}, 32'd1);
        chk("over_err", {31'd0, err}, 32'd1);
        chk("over_in_ready", {31'd0, in_ready}, 32'd0);
        in_data = 8'h77;
        repeat (4) @(negedge clk);
        chk("over_still_done", {31'd0, in_ready | (done ? 1'b0 : 1'b1)}, 32'd0);
        in_valid = 1'b0;
        chk("over_no_we", we_count - wc, 32'd0);

        // Reset mid-load after two data bytes.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_wa", wa, BASE);
        chk("midrst_wd", wd, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(tbl[0], "reload");

        // start pulse mid-frame is ignored.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        send_byte(8'h24, 0);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("midstart_busy", {31'd0, busy}, 32'd1);
        send_byte(8'h80, 0);
        sb_q.push_back({BASE, 32'h3E802403});
        send_byte(8'h3E, 0);
        send_byte(8'h98, 0);
        in_valid = 1'b0;
        chk("midstart_done", {31'd0, done}, 32'd1);
        chk("midstart_err", {31'd0, err}, 32'd0);
        chk("midstart_sb_empty", sb_q.size(), 32'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Writer side of the instruction memory. It receives a program image as a byte stream with valid/ready handshake, assembles little-endian 32-bit words, and writes them into the instruction memory write port starting at the text base address. It verifies a length header and an XOR checksum, and holds the core in reset (`hold_cpu`) while loading. It sits between the host byte link (UART/JTAG bridge) and `imem`.

## Interface
- `BASE_ADDR`, default 32'h00400000: byte address of word 0.
- `DEPTH`, default 64: instruction memory capacity in words; maximum accepted word count.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: one-cycle request to begin a load. Honoured only in IDLE or DONE.
- `in_valid`  in  1: byte-stream valid.
- `in_data`  in  8: byte-stream data.
- `in_ready`  out  1: byte-stream ready.
- `we`  out  1: instruction memory write strobe, one-cycle pulse per word.
- `wa`  out  32: write byte address, always word-aligned.
- `wd`  out  32: write data.
- `busy`  out  1: load in progress (LEN0 through CHK).
- `hold_cpu`  out  1: keep the core in reset. Equals `busy`.
- `done`  out  1: load finished. Held until the next `start`.
- `err`  out  1: valid while `done`. 1 means the checksum mismatched or the length exceeded `DEPTH`.

## Operation
- Frame format:
  - 2 header bytes: N, a 16-bit word count, little-endian.
  - N×4 data bytes: each word little-endian.
  - 1 checksum byte: XOR of every header byte and data byte.
- States: IDLE, LEN0, LEN1, DATA, CHK, DONE.
- State transitions:
  - IDLE: `start` goes to LEN0. Clear byte counter, word index, checksum, `done` and `err`.
  - LEN0: on a handshake, latch N[7:0] and go to LEN1.
  - LEN1: on a handshake, latch N[15:8].
    - If N > `DEPTH`: go to DONE with `err`=1. No writes occur and no further bytes are consumed.
    - If N = 0: go to CHK.
    - Otherwise: go to DATA.
  - DATA: each handshake shifts the byte into bit position 8×k, where k = byte counter 0..3.
    - On k=3, register the word and issue a write, then increment the word index.
    - After the 4th byte of word N−1, go to CHK.
  - CHK: on a handshake, set `err` = (byte ≠ running XOR) and go to DONE.
  - DONE: hold `done`=1 and the `err` value. `start` goes to LEN0 with the same clears as IDLE.
- A handshake is `in_valid && in_ready` at the rising edge.
- `in_ready` = state ∈ {LEN0, LEN1, DATA, CHK}, decoded from the registered state only.
- The checksum accumulates on every handshake in LEN0, LEN1 and DATA.
- `wa` = `BASE_ADDR` + 4×index, computed at 32-bit width. The index is 16 bits.
- `start` in LEN0..CHK is ignored.
- `in_valid` outside the busy states is ignored: no byte is consumed.
- Reset mid-load: all state is lost immediately, outputs return to their reset values, and words already written stay in `imem`.

## Timing
- Reset values:
  - state = IDLE.
  - `in_ready`=0, `we`=0, `wa`=`BASE_ADDR`, `wd`=0.
  - `busy`=0, `hold_cpu`=0, `done`=0, `err`=0.
- `start` sampled at edge t: `busy`=1 and `in_ready`=1 from t+1.
- Write latency: 4th byte of a word accepted at edge t → `we`=1 with valid `wa`/`wd` for exactly the cycle t..t+1.
  - `wa`/`wd` hold their values after the pulse.
- Throughput: one byte per cycle when `in_valid` stays high. `in_ready` is never deasserted mid-frame.
- Checksum byte accepted at edge t: `done`=1, `busy`=0, valid `err` from t+1.
- Oversize N: LEN1 byte accepted at t → `done`=1, `err`=1 from t+1.
- The last data write pulse and the CHK state coincide, so the last word is written before `done` rises.

## Structure
- Shared package `imem_pkg`:
  - `loader_state_t` enum.
  - `TEXT_BASE` = 32'h00400000.
  - `IMEM_DEPTH`.
- `imem` gains a synchronous write port (`we`, `wa`, `wd`) for this block. The read path is unchanged.
- One natural sub-module: `byte_word_packer`, which holds the byte counter and 32-bit shift register and raises `word_valid`. The FSM, index and checksum stay in `imem_loader`.

## Test plan
- Reset with `rst_n`=0, `in_valid`=1, `start`=1 → all outputs at reset values, `in_ready`=0.
- Load 01 00 03 24 80 3E 98 back-to-back → one `we` pulse with `wa`=00400000 and `wd`=3E802403, then `done`=1, `err`=0. Read 00400000 from `imem` → 3E802403.
- Load 3 words (3E802403, 3EC02483, 00940533) with random `in_valid` gaps and the correct checksum → writes at 00400000, 00400004 and 00400008 in order, `err`=0.
- Same frame as the single-word load with checksum 00 → all writes occur, then `done`=1 with `err`=1.
- N=0x0041 with `DEPTH`=64 → `done`=1 and `err`=1 one cycle after the second byte, no `we`. N=0 with checksum 00 → `done`=1, `err`=0.
- `rst_n` pulsed low after 2 data bytes, then `start` and a full single-word frame → clean reload with no stale bytes in `wd`. A `start` pulse mid-frame is ignored.
